puf_eval_ctrl: RTL
==================

Name: puf_eval_ctrl

Overview:
Parametrised single-clock successor of the 6-bit PUF sampling front end. It accepts a challenge, drives the PUF array enable for a programmable settle time, and repeats the evaluation 1..2^NSAMP_W-1 times. It counts ones per response bit and returns a temporal-majority-voted response plus a per-bit Q/Qn-consistency flag. It sits between the bus-side request logic and an external `puf_ary` instance.

Parameters:
Q_W, 6, response width (bits of Q/Qn)
SEL_W, 32, challenge/selection width
WAIT_W, 4, width of settle-count field
NSAMP_W, 4, width of sample-count field and of each per-bit ones counter

Ports:
clk100  in  1  block clock
arstn_clk100  in  1  reset; one clock; reset is asynchronous and active-low
req_i  in  1  start pulse, honoured only when busy_o=0 or valid_o=1
sel_i  in  SEL_W  challenge, captured on accepted req_i
wait_cyc_i  in  WAIT_W  settle cycles minus one per evaluation, captured on accept
nsamp_i  in  NSAMP_W  evaluations per request, captured on accept; 0 treated as 1
puf_sel_o  out  SEL_W  registered challenge to array
puf_ce_o  out  1  array enable
puf_q_i  in  Q_W  array Q
puf_qn_i  in  Q_W  array Qn
busy_o  out  1  request in progress
done_o  out  1  pulse one cycle before valid_o
valid_o  out  1  single-cycle result strobe
Q_o  out  Q_W  majority-voted response, held until next valid_o
invalid_o  out  Q_W  bit set if any sample had puf_q_i[b]==puf_qn_i[b]

Behaviour:
- Reset (async assert, sync deassert at the block's boundary): state IDLE; every output 0, including puf_sel_o, Q_o, and invalid_o. Counters are cleared. Reset asserted mid-operation aborts immediately and drops puf_ce_o in the same instant.
- States:
  - IDLE -> EVAL on accepted req.
  - EVAL: cnt 0..W, W = captured wait; puf_ce_o=1.
  - At cnt==W, sample. If more samples remain, go to RELAX; otherwise go to DONE.
  - RELAX: one cycle, puf_ce_o=0, then back to EVAL with cnt=0.
  - DONE: done_o=1, then VALID.
  - VALID: valid_o=1, Q_o/invalid_o loaded, then IDLE.
- Accept edge: capture sel_i into puf_sel_o, plus wait_cyc_i and nsamp_i (0->1). Clear the ones counters and the invalid accumulator. busy_o=1 from the next cycle.
- Sample: ones[b] += puf_q_i[b]; inv[b] |= (puf_q_i[b] == puf_qn_i[b]).
- Ones counters are NSAMP_W wide. They cannot overflow because N <= 2^NSAMP_W-1.
- Majority: Q_o[b] = (2*ones[b] > N), compared at NSAMP_W+1 bits. A tie (even N) resolves to 0.
- Timing, req on edge 0, N samples, W wait:
  - puf_ce_o high on cycles 1..W+1 for each evaluation, with a 1-cycle gap between evaluations.
  - done_o on cycle N*(W+2).
  - valid_o on cycle N*(W+2)+1.
- busy_o falls on the valid_o cycle. A req_i in that same cycle is accepted: busy_o is high on the next cycle and Q_o is still held.
- req_i while busy_o=1 and valid_o=0 is ignored; puf_sel_o is unchanged.
- sel_i, wait_cyc_i and nsamp_i changing mid-request have no effect.

Optional Feature:
PUF_STAB_MASK_EN:
- Defined: adds output unstable_o [Q_W], loaded on valid_o. A bit is set when ones[b] is neither 0 nor N, i.e. the bit flipped across samples. It resets to 0.
- Undefined: the port is absent. No extra flops are built.

Decomposition:
- Package puf_pkg holds:
  - the state enum (IDLE, EVAL, RELAX, DONE, VALID)
  - default widths for Q_W/SEL_W/WAIT_W/NSAMP_W
  - a function for the effective sample count (0->1)
- One sub-module, puf_vote_bit, instantiated Q_W times via generate. It contains one ones counter, the invalid sticky bit, the majority compare and the optional unstable compare.

Test Plan:
- Q_W=6, nsamp=1, wait=0, puf_q=6'h2A, puf_qn=6'h15, req at cycle 0 -> puf_ce_o high on cycle 1, done_o on cycle 2, valid_o on cycle 3, Q_o=6'h2A, invalid_o=0.
- nsamp=5, wait=3, puf_q = 3F,00,3F,3F,00 across samples, qn=~q -> valid_o on cycle 26, Q_o=6'h3F; with PUF_STAB_MASK_EN, unstable_o=6'h3F.
- nsamp=4 tie, puf_q = 01,01,00,00 -> Q_o=6'h00; unstable_o=6'h01 when enabled.
- One sample with puf_q[3]==puf_qn[3] among 3 samples -> invalid_o=6'h08; other bits voted normally.
- Second req while busy -> ignored, puf_sel_o unchanged. req in the valid_o cycle -> busy_o=1 next cycle and a second valid_o follows at the predicted cycle.
- arstn_clk100 low during EVAL -> puf_ce_o, busy_o and Q_o go 0 without waiting for a clock edge; a later nsamp=0 request behaves as nsamp=1.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF evaluation controller: default widths,
// FSM state encoding and the sample-count fix-up helper.
// Optional feature macro used by the slice: PUF_STAB_MASK_EN.
package puf_pkg;

   localparam int Q_W_DEF     = 6;
   localparam int SEL_W_DEF   = 32;
   localparam int WAIT_W_DEF  = 4;
   localparam int NSAMP_W_DEF = 4;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_EVAL  = 3'd1;
   localparam state_t S_RELAX = 3'd2;
   localparam state_t S_DONE  = 3'd3;
   localparam state_t S_VALID = 3'd4;

   // A requested sample count of zero means one sample: forcing the LSB high
   // when the whole field is zero keeps the helper independent of NSAMP_W.
   function automatic logic nsamp_lsb(input logic is_zero, input logic lsb);
      return lsb | is_zero;
   endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Bus-side request/result bundle of the PUF evaluation controller.
// With PUF_STAB_MASK_EN defined the bundle also carries unstable_o.
interface puf_eval_ctrl_if
   import puf_pkg::*;
#(
   parameter int Q_W     = Q_W_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int WAIT_W  = WAIT_W_DEF,
   parameter int NSAMP_W = NSAMP_W_DEF
) ();

   logic               req_i;
   logic [SEL_W-1:0]   sel_i;
   logic [WAIT_W-1:0]  wait_cyc_i;
   logic [NSAMP_W-1:0] nsamp_i;
   logic               busy_o;
   logic               done_o;
   logic               valid_o;
   logic [Q_W-1:0]     Q_o;
   logic [Q_W-1:0]     invalid_o;
`ifdef PUF_STAB_MASK_EN
   logic [Q_W-1:0]     unstable_o;
`endif

   modport master (
      output req_i, sel_i, wait_cyc_i, nsamp_i,
      input  busy_o, done_o, valid_o, Q_o, invalid_o
`ifdef PUF_STAB_MASK_EN
      , unstable_o
`endif
   );

   modport slave (
      input  req_i, sel_i, wait_cyc_i, nsamp_i,
      output busy_o, done_o, valid_o, Q_o, invalid_o
`ifdef PUF_STAB_MASK_EN
      , unstable_o
`endif
   );

endinterface

// File: rtl/puf_vote_bit.sv
// One response bit: ones counter, sticky Q/Qn-consistency flag, majority
// compare and (with PUF_STAB_MASK_EN) the flip-detection compare.
module puf_vote_bit
   import puf_pkg::*;
#(
   parameter int NSAMP_W = NSAMP_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               smp_i,
   input  logic               q_i,
   input  logic               qn_i,
   input  logic [NSAMP_W-1:0] nsamp_i,
   output logic               maj_o,
`ifdef PUF_STAB_MASK_EN
   output logic               unst_o,
`endif
   output logic               inv_o
);

   logic [NSAMP_W-1:0] ones_q, ones_d;
   logic               inv_q, inv_d;

   // Clear on request accept, accumulate on each sample edge, else hold.
   always_comb begin
      ones_d = ones_q;
      inv_d  = inv_q;
      if (clr_i) begin
         ones_d = '0;
         inv_d  = 1'b0;
      end else if (smp_i) begin
         ones_d = ones_q + {{(NSAMP_W-1){1'b0}}, q_i};
         inv_d  = inv_q | (q_i == qn_i);
      end else begin
         ones_d = ones_q;
         inv_d  = inv_q;
      end
   end

   // Counter and sticky flag state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q <= '0;
         inv_q  <= 1'b0;
      end else begin
         ones_q <= ones_d;
         inv_q  <= inv_d;
      end
   end

   // Strict majority at NSAMP_W+1 bits so a tie on even counts votes 0.
   assign maj_o = ({ones_q, 1'b0} > {1'b0, nsamp_i});
   assign inv_o = inv_q;
`ifdef PUF_STAB_MASK_EN
   assign unst_o = (ones_q != '0) && (ones_q != nsamp_i);
`endif

endmodule

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation controller: settles the array for a programmable time,
// repeats the evaluation N times and returns a temporal-majority vote.
// Optional feature macro: PUF_STAB_MASK_EN (adds unstable_o on the bus).
module puf_eval_ctrl
   import puf_pkg::*;
#(
   parameter int Q_W     = Q_W_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int WAIT_W  = WAIT_W_DEF,
   parameter int NSAMP_W = NSAMP_W_DEF
) (
   input  logic             clk100,
   input  logic             arstn_clk100,
   puf_eval_ctrl_if.slave   bus,
   output logic [SEL_W-1:0] puf_sel_o,
   output logic             puf_ce_o,
   input  logic [Q_W-1:0]   puf_q_i,
   input  logic [Q_W-1:0]   puf_qn_i
);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  cnt_q, cnt_d, wait_q, wait_d;
   logic [NSAMP_W-1:0] nsamp_q, nsamp_d, left_q, left_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               ce_q, ce_d, busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic [Q_W-1:0]     res_q, res_d, inv_q, inv_d;
   logic [Q_W-1:0]     maj_s, invb_s;
   logic [NSAMP_W-1:0] nsamp_eff_s;
   logic               accept_s, clr_s, smp_s;
`ifdef PUF_STAB_MASK_EN
   logic [Q_W-1:0]     unst_q, unst_d, unstb_s;
`endif

   // A request is taken only when idle or in the result-strobe cycle.
   assign accept_s    = bus.req_i && ((state_q == S_IDLE) || (state_q == S_VALID));
   assign nsamp_eff_s = {bus.nsamp_i[NSAMP_W-1:1],
                         nsamp_lsb(bus.nsamp_i == '0, bus.nsamp_i[0])};

   // Sequencing FSM: settle counter, remaining-sample counter and captures.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      nsamp_d = nsamp_q;
      left_d  = left_q;
      sel_d   = sel_q;
      clr_s   = 1'b0;
      smp_s   = 1'b0;
      case (state_q)
         S_IDLE, S_VALID: begin
            if (accept_s) begin
               state_d = S_EVAL;
               cnt_d   = '0;
               wait_d  = bus.wait_cyc_i;
               nsamp_d = nsamp_eff_s;
               left_d  = nsamp_eff_s;
               sel_d   = bus.sel_i;
               clr_s   = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EVAL: begin
            if (cnt_q == wait_q) begin
               smp_s  = 1'b1;
               cnt_d  = '0;
               left_d = left_q - NSAMP_W'(1);
               if (left_q == NSAMP_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RELAX;
               end
            end else begin
               cnt_d = cnt_q + WAIT_W'(1);
            end
         end
         S_RELAX: state_d = S_EVAL;
         S_DONE:  state_d = S_VALID;
         default: state_d = S_IDLE;
      endcase
   end

   // Output flops follow the next state; results load on the DONE->VALID step.
   always_comb begin
      ce_d    = (state_d == S_EVAL);
      busy_d  = (state_d == S_EVAL) || (state_d == S_RELAX) || (state_d == S_DONE);
      done_d  = (state_d == S_DONE);
      valid_d = (state_d == S_VALID);
      if (state_q == S_DONE) begin
         res_d = maj_s;
         inv_d = invb_s;
      end else begin
         res_d = res_q;
         inv_d = inv_q;
      end
`ifdef PUF_STAB_MASK_EN
      if (state_q == S_DONE) begin
         unst_d = unstb_s;
      end else begin
         unst_d = unst_q;
      end
`endif
   end

   // All state and registered outputs; async reset drops puf_ce_o at once.
   always_ff @(posedge clk100 or negedge arstn_clk100) begin
      if (!arstn_clk100) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wait_q  <= '0;
         nsamp_q <= '0;
         left_q  <= '0;
         sel_q   <= '0;
         ce_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         res_q   <= '0;
         inv_q   <= '0;
`ifdef PUF_STAB_MASK_EN
         unst_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         nsamp_q <= nsamp_d;
         left_q  <= left_d;
         sel_q   <= sel_d;
         ce_q    <= ce_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         inv_q   <= inv_d;
`ifdef PUF_STAB_MASK_EN
         unst_q  <= unst_d;
`endif
      end
   end

   for (genvar b = 0; b < Q_W; b++) begin : g_bit
      puf_vote_bit #(.NSAMP_W(NSAMP_W)) u_vote (
         .clk     (clk100),
         .rst_n   (arstn_clk100),
         .clr_i   (clr_s),
         .smp_i   (smp_s),
         .q_i     (puf_q_i[b]),
         .qn_i    (puf_qn_i[b]),
         .nsamp_i (nsamp_q),
         .maj_o   (maj_s[b]),
`ifdef PUF_STAB_MASK_EN
         .unst_o  (unstb_s[b]),
`endif
         .inv_o   (invb_s[b])
      );
   end

   assign puf_sel_o     = sel_q;
   assign puf_ce_o      = ce_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.valid_o   = valid_q;
   assign bus.Q_o       = res_q;
   assign bus.invalid_o = inv_q;
`ifdef PUF_STAB_MASK_EN
   assign bus.unstable_o = unst_q;
`endif

endmodule
